// File: rtl/clk_rst_seq.sv
// Reset stretcher and multi-channel clock-enable generator with halt/single-step.
// Releases sys_reset_n RST_HOLD edges after reset drops, then emits per-channel enable pulses and square waves.
module clk_rst_seq #(
  parameter int NUM_CH   = 2,
  parameter int DIV_W    = 16,
  parameter int RST_HOLD = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  input  logic                    halt_i,
  input  logic                    step_i,
  output logic                    sys_reset_n,
  output logic [NUM_CH-1:0]       ce_o,
  output logic [NUM_CH-1:0]       sq_o,
  output logic                    running_o
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t              state_r;
  logic [HOLD_W-1:0]   hold_cnt_r;
  logic [DIV_W-1:0]    cnt_r [NUM_CH];
  logic                step_prev_r;

  logic [DIV_W-1:0]    div_s [NUM_CH];
  logic [DIV_W-1:0]    cnt_inc_s [NUM_CH];
  logic [NUM_CH-1:0]   ch_en_s;
  logic [NUM_CH-1:0]   wrap_s;
  logic                step_rise_s;
  logic                hold_done_s;

  // Per-channel divisor slicing and wrap detection; >= lets a lowered divisor wrap at once.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      div_s[i]     = div_i[i*DIV_W +: DIV_W];
      ch_en_s[i]   = (div_s[i] != {DIV_W{1'b0}});
      wrap_s[i]    = ch_en_s[i] && (cnt_r[i] >= (div_s[i] - {{(DIV_W-1){1'b0}}, 1'b1}));
      cnt_inc_s[i] = cnt_r[i] + {{(DIV_W-1){1'b0}}, 1'b1};
    end
    step_rise_s = step_i & ~step_prev_r;
    hold_done_s = (hold_cnt_r == HOLD_W'(RST_HOLD - 1));
  end

  // Sequencer state, channel counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_HOLD;
      hold_cnt_r  <= {HOLD_W{1'b0}};
      step_prev_r <= 1'b0;
      sys_reset_n <= 1'b0;
      running_o   <= 1'b0;
      ce_o        <= {NUM_CH{1'b0}};
      sq_o        <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i] <= {DIV_W{1'b0}};
      end
    end else begin
      step_prev_r <= step_i;
      case (state_r)
        ST_HOLD: begin
          ce_o       <= {NUM_CH{1'b0}};
          hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          if (hold_done_s) begin
            sys_reset_n <= 1'b1;
            state_r     <= halt_i ? ST_HALT : ST_RUN;
            running_o   <= ~halt_i;
          end else begin
            sys_reset_n <= 1'b0;
            running_o   <= 1'b0;
          end
        end

        ST_RUN: begin
          if (halt_i) begin
            state_r   <= ST_HALT;
            running_o <= 1'b0;
            ce_o      <= {NUM_CH{1'b0}};
          end else begin
            running_o <= 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
              if (!ch_en_s[i]) begin
                cnt_r[i] <= {DIV_W{1'b0}};
                ce_o[i]  <= 1'b0;
              end else if (wrap_s[i]) begin
                cnt_r[i] <= {DIV_W{1'b0}};
                ce_o[i]  <= 1'b1;
                sq_o[i]  <= ~sq_o[i];
              end else begin
                cnt_r[i] <= cnt_inc_s[i];
                ce_o[i]  <= 1'b0;
              end
            end
          end
        end

        // Counters stay frozen here, including on the edge that returns to RUN.
        ST_HALT: begin
          if (!halt_i) begin
            state_r   <= ST_RUN;
            running_o <= 1'b1;
            ce_o      <= {NUM_CH{1'b0}};
          end else begin
            running_o <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
              if (step_rise_s && ch_en_s[i]) begin
                ce_o[i] <= 1'b1;
                sq_o[i] <= ~sq_o[i];
              end else begin
                ce_o[i] <= 1'b0;
              end
            end
          end
        end

        default: begin
          state_r     <= ST_HOLD;
          hold_cnt_r  <= {HOLD_W{1'b0}};
          sys_reset_n <= 1'b0;
          running_o   <= 1'b0;
          ce_o        <= {NUM_CH{1'b0}};
        end
      endcase
    end
  end

endmodule
